// File: rtl/hdmi_video_tx.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_video_tx
// Purpose  : 1280x720@60 (CEA VIC 4) video transmit core. Generates the
//            raster counters, sync and data-enable timing, and the three
//            TMDS 8b/10b symbol streams handed to an external 10:1
//            serializer. HDMI mode adds the video preamble and guard band
//            ahead of every active line; DVI mode sends plain control tokens.
// Ports    : clk_pixel     - 74.25 MHz pixel clock, rising edge
//            resetn        - asynchronous active-low reset
//            rgb           - {R,G,B} for the pixel addressed by cx/cy now
//            cx, cy        - raster position (0..1649, 0..749)
//            frame_width   - constant 1280
//            frame_height  - constant 720
//            tmds0/1/2     - 10-bit TMDS symbols (blue, green, red), LSB first
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_video_tx #(
  parameter int DVI_OUTPUT = 0,
  parameter int START_X    = 0,
  parameter int START_Y    = 0
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  input  logic [23:0] rgb,
  output logic [10:0] cx,
  output logic [9:0]  cy,
  output logic [10:0] frame_width,
  output logic [9:0]  frame_height,
  output logic [9:0]  tmds0,
  output logic [9:0]  tmds1,
  output logic [9:0]  tmds2
);

  localparam logic [10:0] H_TOTAL_M1 = 11'd1649;
  localparam logic [9:0]  V_TOTAL_M1 = 10'd749;
  localparam logic [10:0] H_ACTIVE   = 11'd1280;
  localparam logic [9:0]  V_ACTIVE   = 10'd720;
  localparam logic [10:0] START_X_L  = START_X[10:0];
  localparam logic [9:0]  START_Y_L  = START_Y[9:0];

  localparam logic [9:0] TOKEN_00   = 10'b1101010100;
  localparam logic [9:0] TOKEN_01   = 10'b0010101011;
  localparam logic [9:0] TOKEN_10   = 10'b0101010100;
  localparam logic [9:0] TOKEN_11   = 10'b1010101011;
  localparam logic [9:0] GUARD_0_2  = 10'b1011001100;
  localparam logic [9:0] GUARD_1    = 10'b0100110011;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_00;
      2'b01:   t = TOKEN_01;
      2'b10:   t = TOKEN_10;
      default: t = TOKEN_11;
    endcase
    return t;
  endfunction

  assign frame_width  = H_ACTIVE;
  assign frame_height = V_ACTIVE;

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      cx <= START_X_L;
      cy <= START_Y_L;
    end else if (cx == H_TOTAL_M1) begin
      cx <= '0;
      cy <= (cy == V_TOTAL_M1) ? '0 : cy + 10'd1;
    end else begin
      cx <= cx + 11'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Timing decode for the current raster position
  // --------------------------------------------------------------------------
  logic de, hsync, vsync, island_line, preamble, guard;

  always_comb begin
    de          = (cx < H_ACTIVE) && (cy < V_ACTIVE);
    hsync       = (cx >= 11'd1390) && (cx <= 11'd1429);
    vsync       = (cy >= 10'd725) && (cy <= 10'd729);
    // Preamble/guard band only precede a line that will carry pixels.
    island_line = (DVI_OUTPUT == 0) && ((cy == V_TOTAL_M1) || (cy <= 10'd718));
    preamble    = island_line && (cx >= 11'd1640) && (cx <= 11'd1647);
    guard       = island_line && (cx >= 11'd1648);
  end

  logic [1:0] ctrl     [3];
  logic [9:0] guard_sym[3];

  always_comb begin
    ctrl[0]      = {vsync, hsync};
    ctrl[1]      = {1'b0, preamble};
    ctrl[2]      = 2'b00;
    guard_sym[0] = GUARD_0_2;
    guard_sym[1] = GUARD_1;
    guard_sym[2] = GUARD_0_2;
  end

  // --------------------------------------------------------------------------
  // Per-channel TMDS encoder: channel 0 blue, 1 green, 2 red
  // --------------------------------------------------------------------------
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [7:0] d;
    logic [8:0] qm;
    logic [3:0] n1d;
    logic [3:0] n1q;
    logic       xnor_sel;
    // Running disparity kept as 5-bit two's complement; sign read from bit 4.
    logic [4:0] cnt;
    logic [4:0] cnt_nx;
    logic [4:0] diff;
    logic [9:0] q_data;
    logic [9:0] sym;

    assign d = rgb[8*ch +: 8];

    always_comb begin
      n1d = '0;
      for (int k = 0; k < 8; k++) n1d = n1d + {3'b000, d[k]};
      xnor_sel = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);

      qm    = '0;
      qm[0] = d[0];
      for (int k = 1; k < 8; k++)
        qm[k] = xnor_sel ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
      qm[8] = ~xnor_sel;

      n1q = '0;
      for (int k = 0; k < 8; k++) n1q = n1q + {3'b000, qm[k]};
      // n1 - n0 = 2*n1 - 8, taken modulo 32
      diff = {n1q, 1'b0} - 5'd8;

      if ((cnt == 5'd0) || (n1q == 4'd4)) begin
        q_data = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
        cnt_nx = qm[8] ? (cnt + diff) : (cnt - diff);
      end else if ((!cnt[4] && (n1q > 4'd4)) || (cnt[4] && (n1q < 4'd4))) begin
        q_data = {1'b1, qm[8], ~qm[7:0]};
        cnt_nx = cnt + {3'b000, qm[8], 1'b0} - diff;
      end else begin
        q_data = {1'b0, qm[8], qm[7:0]};
        cnt_nx = cnt - {3'b000, ~qm[8], 1'b0} + diff;
      end
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
        sym <= TOKEN_00;
        cnt <= '0;
      end else if (de) begin
        sym <= q_data;
        cnt <= cnt_nx;
      end else begin
        sym <= guard ? guard_sym[ch] : ctrl_token(ctrl[ch]);
        cnt <= '0;
      end
    end
  end

  assign tmds0 = g_ch[0].sym;
  assign tmds1 = g_ch[1].sym;
  assign tmds2 = g_ch[2].sym;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_video_tx
// Purpose  : Self-checking bench for hdmi_video_tx. Starts the raster at
//            line 718 so that active lines, the vertical blanking interval
//            and the wrap into a new frame all fit in a short run. A
//            behavioural model tracks raster position and disparity and
//            predicts every symbol; fixed literals pin key symbols.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_video_tx;

  localparam int SX = 0;
  localparam int SY = 718;
  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] G02 = 10'b1011001100;
  localparam logic [9:0] G1  = 10'b0100110011;

  logic        clk_pixel = 1'b0;
  logic        resetn;
  logic [23:0] rgb;
  logic [10:0] cx;
  logic [9:0]  cy;
  logic [10:0] frame_width;
  logic [9:0]  frame_height;
  logic [9:0]  tmds0, tmds1, tmds2;

  hdmi_video_tx #(
    .DVI_OUTPUT(0),
    .START_X   (SX),
    .START_Y   (SY)
  ) dut (
    .clk_pixel   (clk_pixel),
    .resetn      (resetn),
    .rgb         (rgb),
    .cx          (cx),
    .cy          (cy),
    .frame_width (frame_width),
    .frame_height(frame_height),
    .tmds0       (tmds0),
    .tmds1       (tmds1),
    .tmds2       (tmds2)
  );

  always #5 clk_pixel = ~clk_pixel;

  int tests = 0;
  int fails = 0;

  // Model state
  int mx, my;
  int mcnt[3];

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [9:0] token(input int c);
    case (c)
      0:       return T00;
      1:       return T01;
      2:       return T10;
      default: return T11;
    endcase
  endfunction

  // 8b/10b data encoding from the DVI rules, with integer disparity.
  function automatic logic [9:0] encode(input logic [7:0] d, input int cin, output int cout);
    logic [8:0] qm;
    logic [9:0] q;
    int n1d, n1q, n0q;
    n1d = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int k = 1; k < 8; k++) qm[k] = ~(qm[k-1] ^ d[k]);
      qm[8] = 1'b0;
    end else begin
      for (int k = 1; k < 8; k++) qm[k] = qm[k-1] ^ d[k];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (cin == 0 || n1q == n0q) begin
      q    = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cout = cin + (qm[8] ? (n1q - n0q) : (n0q - n1q));
    end else if ((cin > 0 && n1q > n0q) || (cin < 0 && n0q > n1q)) begin
      q    = {1'b1, qm[8], ~qm[7:0]};
      cout = cin + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q    = {1'b0, qm[8], qm[7:0]};
      cout = cin - 2 * (qm[8] ? 0 : 1) + n1q - n0q;
    end
    return q;
  endfunction

  // Predict the three symbols for raster (x,y) with pixel p; updates mcnt.
  task automatic predict(input int x, input int y, input logic [23:0] p,
                         output logic [9:0] e0, output logic [9:0] e1, output logic [9:0] e2);
    logic [9:0] e[3];
    bit de, hs, vs, line_ok;
    int nc;
    de      = (x < 1280) && (y < 720);
    hs      = (x >= 1390) && (x <= 1429);
    vs      = (y >= 725) && (y <= 729);
    line_ok = (y == 749) || (y <= 718);
    for (int c = 0; c < 3; c++) begin
      if (de) begin
        e[c]    = encode(p[8*c +: 8], mcnt[c], nc);
        mcnt[c] = nc;
      end else begin
        mcnt[c] = 0;
        if (line_ok && x >= 1648)
          e[c] = (c == 1) ? G1 : G02;
        else if (c == 0)
          e[c] = token(2 * int'(vs) + int'(hs));
        else if (c == 1)
          e[c] = token((line_ok && x >= 1640) ? 1 : 0);
        else
          e[c] = T00;
      end
    end
    e0 = e[0];
    e1 = e[1];
    e2 = e[2];
  endtask

  task automatic model_reset();
    mx = SX;
    my = SY;
    for (int c = 0; c < 3; c++) mcnt[c] = 0;
  endtask

  // Runs n pixel clocks starting at a falling edge, checking every cycle.
  task automatic run_cycles(input int n);
    logic [9:0] e0, e1, e2;
    int px, py;
    for (int i = 0; i < n; i++) begin
      check("cx", int'(cx), mx);
      check("cy", int'(cy), my);
      if (mx == 0 && my == SY)      rgb = 24'hFFFFFF;
      else if (mx == 0 && my == 0)  rgb = 24'h000000;
      else                          rgb = 24'($urandom);
      px = mx;
      py = my;
      @(posedge clk_pixel);
      predict(px, py, rgb, e0, e1, e2);
      mx = (mx == 1649) ? 0 : mx + 1;
      if (px == 1649) my = (my == 749) ? 0 : my + 1;
      #1;
      check("tmds0", int'(tmds0), int'(e0));
      check("tmds1", int'(tmds1), int'(e1));
      check("tmds2", int'(tmds2), int'(e2));
      // Fixed expectations at hand-picked positions
      if (px == 0 && py == SY) begin
        check("lit_ffffff_t0", int'(tmds0), int'(10'b1000000000));
        check("lit_ffffff_t2", int'(tmds2), int'(10'b1000000000));
      end
      if (px == 0 && py == 0) begin
        check("lit_000000_t0", int'(tmds0), int'(10'b0100000000));
        check("lit_000000_t1", int'(tmds1), int'(10'b0100000000));
        check("lit_000000_t2", int'(tmds2), int'(10'b0100000000));
      end
      if (px == 1400 && py == 730) check("lit_hsync", int'(tmds0), int'(T01));
      if (px == 1400 && py == 727) check("lit_hvsync", int'(tmds0), int'(T11));
      if (px == 100 && py == 727)  check("lit_vsync", int'(tmds0), int'(T10));
      if ((px == 1640 || px == 1647) && (py == 718 || py == 749)) begin
        check("lit_pre_t1", int'(tmds1), int'(T01));
        check("lit_pre_t2", int'(tmds2), int'(T00));
      end
      if ((px == 1648 || px == 1649) && (py == 718 || py == 749)) begin
        check("lit_gb_t0", int'(tmds0), int'(G02));
        check("lit_gb_t1", int'(tmds1), int'(G1));
        check("lit_gb_t2", int'(tmds2), int'(G02));
      end
      if ((px == 1640 || px == 1648) && (py == 719 || py == 720)) begin
        check("lit_nopre_t0", int'(tmds0), int'(T00));
        check("lit_nopre_t1", int'(tmds1), int'(T00));
      end
      if (px == 1280 && py == 0) check("lit_first_blank", int'(tmds1), int'(T00));
      @(negedge clk_pixel);
    end
  endtask

  initial begin
    resetn = 1'b0;
    rgb    = '0;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_cx", int'(cx), SX);
    check("rst_cy", int'(cy), SY);
    check("rst_tmds0", int'(tmds0), int'(T00));
    check("rst_tmds1", int'(tmds1), int'(T00));
    check("rst_tmds2", int'(tmds2), int'(T00));
    check("frame_width", int'(frame_width), 1280);
    check("frame_height", int'(frame_height), 720);

    @(negedge clk_pixel);
    resetn = 1'b1;
    model_reset();
    // Lines 718..749 then 0..1 of the next frame
    run_cycles(34 * 1650);

    // Asynchronous reset in the middle of a clock period
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_cx", int'(cx), SX);
    check("midrst_cy", int'(cy), SY);
    check("midrst_tmds0", int'(tmds0), int'(T00));
    check("midrst_tmds1", int'(tmds1), int'(T00));
    check("midrst_tmds2", int'(tmds2), int'(T00));
    @(negedge clk_pixel);
    resetn = 1'b1;
    model_reset();
    run_cycles(2000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
